// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker
//   Built-in self-test stage for the two-input logic-gate block. It drives
//   a/b through the four input combinations PASSES times. Each vector is held
//   for SETTLE_CYCLES+1 cycles. The seven gate outputs are sampled at the
//   edge that ends each vector and compared with the truth table.
//
// Parameters
//   SETTLE_CYCLES  0..15   cycles a vector is held before its sample cycle
//   PASSES         1..255  full 4-vector sweeps per run
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a run (accepted only in IDLE or DONE)
//   a_out      gate block input a (registered, = idx[1])
//   b_out      gate block input b (registered, = idx[0])
//   gates_in   gate outputs {xnor,xor,nor,nand,not a,or,and}
//   busy       run in progress
//   done       run finished, results valid until next accepted start
//   pass       1 iff err_count==0 (valid with done)
//   err_count  saturating count of mismatching output bits
//   fail_vec   sticky per-gate mismatch mask
//
// Optional feature (macro GATE_SWEEP_FIRST_FAIL_EN)
//   first_fail_idx / first_fail_pass / first_fail_mask capture the vector
//   index, the pass number and the mismatch mask of the first failing sample.
module gate_sweep_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic [6:0] gates_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [6:0] fail_vec
`ifdef GATE_SWEEP_FIRST_FAIL_EN
  ,
  output logic [1:0] first_fail_idx,
  output logic [7:0] first_fail_pass,
  output logic [6:0] first_fail_mask
`endif
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  // Last value of the settle counter before moving on to SAMPLE.
  localparam logic [3:0] SETTLE_LAST = 4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [7:0] PASS_LAST   = 8'(PASSES - 1);
  // With no settle time every vector is a single SAMPLE cycle.
  localparam bit         NO_SETTLE   = (SETTLE_CYCLES == 0);

  // Truth table of the gate block, indexed by {a,b}.
  function automatic logic [6:0] exp_gates(input logic [1:0] i);
    case (i)
      2'd0:    exp_gates = 7'h5C;
      2'd1:    exp_gates = 7'h2E;
      2'd2:    exp_gates = 7'h2A;
      default: exp_gates = 7'h43;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic [3:0]  scnt_q, scnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [7:0]  err_q, err_d;
  logic [6:0]  fail_q, fail_d;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
  logic [1:0]  ffi_q, ffi_d;
  logic [7:0]  ffp_q, ffp_d;
  logic [6:0]  ffm_q, ffm_d;
`endif

  logic        accept;
  logic        last_vec;
  logic        settle_end;
  logic [6:0]  mm;
  logic [3:0]  mm_cnt;
  logic [8:0]  err_sum;
  logic [7:0]  err_sat;

  assign accept     = start && (state_q == IDLE || state_q == DONE);
  assign last_vec   = (idx_q == 2'd3) && (pcnt_q == PASS_LAST);
  assign settle_end = (scnt_q == SETTLE_LAST);
  assign mm         = gates_in ^ exp_gates(idx_q);

  always_comb begin
    mm_cnt = 4'd0;
    for (int i = 0; i < 7; i++) mm_cnt = mm_cnt + {3'd0, mm[i]};
  end

  // 9-bit sum so an overflow past 255 can be clamped.
  assign err_sum = {1'b0, err_q} + {5'd0, mm_cnt};
  assign err_sat = err_sum[8] ? 8'hFF : err_sum[7:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (NO_SETTLE) state_d = SAMPLE;
          else           state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_end) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (last_vec)       state_d = DONE;
        else if (NO_SETTLE) state_d = SAMPLE;
        else                state_d = SETTLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    idx_d  = idx_q;
    pcnt_d = pcnt_q;
    scnt_d = scnt_q;
    busy_d = busy_q;
    done_d = done_q;
    pass_d = pass_q;
    err_d  = err_q;
    fail_d = fail_q;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    ffi_d  = ffi_q;
    ffp_d  = ffp_q;
    ffm_d  = ffm_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          idx_d  = 2'd0;
          pcnt_d = 8'd0;
          scnt_d = 4'd0;
          busy_d = 1'b1;
          done_d = 1'b0;
          pass_d = 1'b0;
          err_d  = 8'd0;
          fail_d = 7'd0;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
          ffi_d  = 2'd0;
          ffp_d  = 8'd0;
          ffm_d  = 7'd0;
`endif
        end
      end
      SETTLE: begin
        scnt_d = settle_end ? 4'd0 : scnt_q + 4'd1;
      end
      SAMPLE: begin
        err_d  = err_sat;
        fail_d = fail_q | mm;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        // fail_q is still zero only until the first mismatch of the run.
        if (mm != 7'd0 && fail_q == 7'd0) begin
          ffi_d = idx_q;
          ffp_d = pcnt_q;
          ffm_d = mm;
        end
`endif
        if (last_vec) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (err_sat == 8'd0);
        end else begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) pcnt_d = pcnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= 2'd0;
      pcnt_q <= 8'd0;
      scnt_q <= 4'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= 8'd0;
      fail_q <= 7'd0;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
      ffi_q  <= 2'd0;
      ffp_q  <= 8'd0;
      ffm_q  <= 7'd0;
`endif
    end else begin
      idx_q  <= idx_d;
      pcnt_q <= pcnt_d;
      scnt_q <= scnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      err_q  <= err_d;
      fail_q <= fail_d;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
      ffi_q  <= ffi_d;
      ffp_q  <= ffp_d;
      ffm_q  <= ffm_d;
`endif
    end
  end

  // idx_q is a flop, so a/b come straight from registers and hold (1,1) in DONE.
  assign a_out     = idx_q[1];
  assign b_out     = idx_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
  assign first_fail_idx  = ffi_q;
  assign first_fail_pass = ffp_q;
  assign first_fail_mask = ffm_q;
`endif

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Sequential stimulus and checker stage that wraps the two-input logic-gate block. It drives the gate block's `a`/`b` inputs through all four input combinations and samples the seven gate outputs after a programmable settle time. Each sampled output is compared against the expected truth table. It reports pass/fail, a saturating mismatch count and a sticky per-gate failure mask, and serves as the built-in self-test for the gate block.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling; legal range 0..15.
- `PASSES`, default 1: number of full 4-vector sweeps per run; legal range 1..255.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `start`  input  1  begin a run; sampled in IDLE or DONE only.
- `a_out`  output  1  drives gate block input `a`; registered.
- `b_out`  output  1  drives gate block input `b`; registered.
- `gates_in`  input  7  gate outputs: [0] and, [1] or, [2] not(a), [3] nand, [4] nor, [5] xor, [6] xnor.
- `busy`  output  1  high while a run is in progress.
- `done`  output  1  high from run completion until the next accepted `start`.
- `pass`  output  1  valid when `done`=1; 1 iff `err_count`=0.
- `err_count`  output  8  mismatching output bits across the run, saturating at 255.
- `fail_vec`  output  7  sticky mask; bit i=1 if `gates_in[i]` mismatched at any sample.

## Operation
- States:
  - IDLE: after reset.
  - SETTLE: holding a vector, settle counter running.
  - SAMPLE: one cycle, compare and advance.
  - DONE: run finished, results held.
- Vector index `idx` runs 0..3. Drive `a_out`=`idx[1]` and `b_out`=`idx[0]`.
- Expected `gates_in` per index:
  - idx 0 (a=0, b=0): 7'h5C.
  - idx 1 (a=0, b=1): 7'h2E.
  - idx 2 (a=1, b=0): 7'h2A.
  - idx 3 (a=1, b=1): 7'h43.
- IDLE/DONE + `start`=1 → SETTLE:
  - idx=0 and pass counter=0.
  - `err_count`, `fail_vec` and `done` cleared; `busy`=1.
- SETTLE: count SETTLE_CYCLES cycles, then go to SAMPLE. With SETTLE_CYCLES=0, go straight to SAMPLE.
- SAMPLE:
  - Compute `mm = gates_in ^ expected[idx]`.
  - `err_count += popcount(mm)`, saturating at 255.
  - `fail_vec |= mm`.
  - If idx=3 and pass counter=PASSES-1 → DONE. Otherwise advance idx (wrapping 3→0 and incrementing the pass counter) and return to SETTLE.
- Entering DONE: `busy`=0, `done`=1, `pass` = (final `err_count`==0).
- DONE holds all results; `a_out`/`b_out` hold the last vector (1,1).
- `start` while `busy`=1 is ignored.
- `start` held high continuously in DONE restarts a run every time DONE is reached.
- Reset values:
  - State IDLE.
  - `a_out`=0, `b_out`=0, `busy`=0, `done`=0, `pass`=0.
  - `err_count`=0, `fail_vec`=0.
  - All internal counters 0.
- Reset mid-run aborts immediately to these values; no partial results are retained.

## Timing
- Edge E0 accepts `start`: `a_out`/`b_out` show vector 0 and `busy`=1 after E0.
- Each vector lasts SETTLE_CYCLES+1 cycles. Its compare happens at the edge that ends the vector, and that same edge drives the next vector.
- The final compare edge is E0 + 4·(SETTLE_CYCLES+1)·PASSES. `done`, `pass` and the final `err_count`/`fail_vec` are visible after that edge.
- `err_count` and `fail_vec` update only at SAMPLE edges.
- `gates_in` must be stable for at least one full cycle before the sample edge. The registered `a_out`/`b_out` give at least one full cycle even when SETTLE_CYCLES=0.

## Configuration
- `GATE_SWEEP_FIRST_FAIL_EN` defined:
  - Adds outputs `first_fail_idx` (2 bits), `first_fail_pass` (8 bits) and `first_fail_mask` (7 bits).
  - They capture `idx`, pass number and `mm` at the first SAMPLE with `mm`≠0.
  - They are cleared on reset and on an accepted `start`, and are held otherwise.
  - With no failure in the run, they stay 0.
- Macro undefined: these ports and their registers do not exist; all other behaviour is identical.

## Test plan
- Good gate model, SETTLE_CYCLES=2, PASSES=1, pulse `start` → `done` after 12 cycles, `pass`=1, `err_count`=0, `fail_vec`=0, `a_out`/`b_out` sequence 00,01,10,11 with 3 cycles each.
- `gates_in[5]` stuck-at-0 → `err_count`=2, `fail_vec`=7'h20, `pass`=0; with the macro: `first_fail_idx`=1, `first_fail_mask`=7'h20.
- `gates_in` tied to 0, PASSES=1 → `err_count`=14 (4+4+3+3), `fail_vec`=7'h7F.
- `gates_in` tied to 0, PASSES=20 → 280 raw mismatches give `err_count`=255 (saturated), `done` at 240·(SETTLE_CYCLES+1)/3 cycles (80 at SETTLE_CYCLES=0).
- `rst_n` low during vector 2 → all outputs return to reset values immediately; a new `start` then runs a clean full sweep.
- `start` pulsed while `busy`=1 → ignored, completion time unchanged; `start` in DONE → `done` cleared and counts cleared after one edge.
